// File: rtl/sram_1p_bm_pipe_behavioral.sv
// sram_1p_bm_pipe_behavioral: single-port bit-masked SRAM model with post-reset
// zero-fill engine, write-through reads and a 1- or 2-clock registered read path.
module sram_1p_bm_pipe_behavioral #(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14,
    parameter int P_ADDR_MAX   = (1 << P_ADDR_WIDTH) - 1,
    parameter int P_RD_LAT     = 1,
    parameter int P_CLR_ON_RST = 1
) (
    input  logic                    A_CLK,
    input  logic                    A_RST_N,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [P_DATA_WIDTH-1:0] A_DIN,
    input  logic [P_DATA_WIDTH-1:0] A_BM,
    input  logic                    A_MEN,
    input  logic                    A_WEN,
    input  logic                    A_REN,
    input  logic                    A_DLY,
    output logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BUSY,
    output logic                    A_ERR
);
    localparam logic [P_ADDR_WIDTH-1:0] addr_max = P_ADDR_MAX[P_ADDR_WIDTH-1:0];
    localparam logic clr_on_rst = P_CLR_ON_RST != 0;
    localparam logic two_stage = P_RD_LAT != 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state;
    logic fill_req, s1_v, addr_ok, act, wr, rd, bad, unused_dly;
    logic [P_ADDR_WIDTH-1:0] fill_cnt, idx;
    logic [P_DATA_WIDTH-1:0] mem [0:P_ADDR_MAX];
    logic [P_DATA_WIDTH-1:0] old_word, merged, rd_word, s1;

    assign unused_dly = A_DLY;
    // fill_req keeps the cycle right after reset release away from user access
    assign act      = A_MEN && state == IDLE && !fill_req;
    assign addr_ok  = A_ADDR <= addr_max;
    assign wr       = act && A_WEN && addr_ok;
    assign rd       = act && A_REN && addr_ok;
    assign bad      = act && (A_WEN || A_REN) && !addr_ok;
    assign idx      = addr_ok ? A_ADDR : '0;
    assign old_word = mem[idx];
    assign merged   = (old_word & ~A_BM) | (A_DIN & A_BM);
    assign rd_word  = A_WEN ? merged : old_word;

    always_ff @(posedge A_CLK) begin
        if (state == FILL)
            mem[fill_cnt] <= '0;
        else if (wr)
            mem[idx] <= merged;
    end

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            state    <= IDLE;
            A_BUSY   <= 1'b0;
            fill_req <= clr_on_rst;
            fill_cnt <= '0;
            A_ERR    <= 1'b0;
            s1       <= '0;
            s1_v     <= 1'b0;
            A_DOUT   <= '0;
        end else begin
            A_ERR <= bad;
            if (state == IDLE && fill_req) begin
                state    <= FILL;
                A_BUSY   <= 1'b1;
                fill_req <= 1'b0;
                fill_cnt <= '0;
            end else if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == addr_max) begin
                    state  <= IDLE;
                    A_BUSY <= 1'b0;
                end
            end
            s1_v <= rd && two_stage;
            s1   <= rd ? rd_word : s1;
            if (!two_stage) begin
                if (rd)
                    A_DOUT <= rd_word;
            end else if (s1_v) begin
                A_DOUT <= s1;
            end
        end
    end
endmodule

// File: tb/tb_sram_1p_bm_pipe_behavioral.sv
// tb_sram_1p_bm_pipe_behavioral: two instances (latency 1 full depth 16, latency 2 depth 10)
// driven in parallel and compared against an array-based reference model.
module tb_sram_1p_bm_pipe_behavioral;
    logic clk = 1'b0, rst_n = 1'b0, men = 1'b0, wen = 1'b0, ren = 1'b0, dly = 1'b0;
    logic [3:0] addr = '0;
    logic [23:0] din = '0, bm = '0;
    logic [23:0] dout1, dout2;
    logic busy1, busy2, err1, err2;
    int checks = 0, errors = 0;
    int n1, n2;
    logic [23:0] m1 [16];
    logic [23:0] m2 [10];
    logic [23:0] e_dout1, e_dout2, pend2;
    logic pend2_v, e_err1, e_err2;

    always #5 clk = ~clk;

    sram_1p_bm_pipe_behavioral #(.P_DATA_WIDTH(24), .P_ADDR_WIDTH(4), .P_ADDR_MAX(15),
        .P_RD_LAT(1), .P_CLR_ON_RST(1)) u1 (
        .A_CLK(clk), .A_RST_N(rst_n), .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_MEN(men),
        .A_WEN(wen), .A_REN(ren), .A_DLY(dly), .A_DOUT(dout1), .A_BUSY(busy1), .A_ERR(err1));

    sram_1p_bm_pipe_behavioral #(.P_DATA_WIDTH(24), .P_ADDR_WIDTH(4), .P_ADDR_MAX(9),
        .P_RD_LAT(2), .P_CLR_ON_RST(1)) u2 (
        .A_CLK(clk), .A_RST_N(rst_n), .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_MEN(men),
        .A_WEN(wen), .A_REN(ren), .A_DLY(dly), .A_DOUT(dout2), .A_BUSY(busy2), .A_ERR(err2));

    task automatic model_reset();
        e_dout1 = '0;
        e_dout2 = '0;
        pend2_v = 1'b0;
        e_err1  = 1'b0;
        e_err2  = 1'b0;
    endtask

    task automatic wait_fill();
        men = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 200; i++) begin
            dly = 1'($urandom);
            @(posedge clk);
            #1;
            n1 += int'(busy1);
            n2 += int'(busy2);
            if (!busy1 && !busy2) break;
        end
        foreach (m1[i]) m1[i] = '0;
        foreach (m2[i]) m2[i] = '0;
    endtask

    task automatic step(input logic s_men, input logic s_wen, input logic s_ren,
                        input logic [3:0] a, input logic [23:0] d, input logic [23:0] b);
        logic [23:0] o, mg;
        men = s_men; wen = s_wen; ren = s_ren; addr = a; din = d; bm = b;
        dly = 1'($urandom);
        @(posedge clk);
        #1;
        o = m1[a];
        mg = (o & ~b) | (d & b);
        if (s_men && s_wen) m1[a] = mg;
        if (s_men && s_ren) e_dout1 = s_wen ? mg : o;
        e_err1 = 1'b0;
        e_err2 = s_men && (s_wen || s_ren) && a > 4'd9;
        if (pend2_v) e_dout2 = pend2;
        pend2_v = 1'b0;
        if (s_men && a <= 4'd9) begin
            o = m2[a];
            mg = (o & ~b) | (d & b);
            if (s_wen) m2[a] = mg;
            if (s_ren) begin
                pend2_v = 1'b1;
                pend2 = s_wen ? mg : o;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (dout1 !== 24'h0) begin errors++; $display("FAIL reset_dout1: got %h want 0", dout1); end
        if (dout2 !== 24'h0) begin errors++; $display("FAIL reset_dout2: got %h want 0", dout2); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b want 0", busy2); end
        if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b want 0", err1); end
        if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err2: got %b want 0", err2); end
        rst_n = 1'b1;
        model_reset();
        wait_fill();
        checks += 2;
        if (n1 != 16) begin errors++; $display("FAIL fill_len1: got %0d want 16", n1); end
        if (n2 != 10) begin errors++; $display("FAIL fill_len2: got %0d want 10", n2); end
    endtask

    task automatic test_fill_zero();
        for (int a = 0; a < 16; a++) begin
            step(1'b1, 1'b0, 1'b1, 4'(a), 24'($urandom), 24'($urandom));
            checks += 3;
            if (dout1 !== 24'h0) begin errors++; $display("FAIL zero_dout1[%0d]: got %h want 0", a, dout1); end
            if (dout2 !== 24'h0) begin errors++; $display("FAIL zero_dout2[%0d]: got %h want 0", a, dout2); end
            if (err2 !== (a > 9)) begin errors++; $display("FAIL zero_err2[%0d]: got %b want %b", a, err2, a > 9); end
        end
    endtask

    task automatic test_mask();
        step(1'b1, 1'b1, 1'b0, 4'd3, 24'hABCDEF, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b0, 4'd3, 24'h123456, 24'h00FF00);
        step(1'b1, 1'b0, 1'b1, 4'd3, 24'h0, 24'h0);
        checks++;
        if (dout1 !== 24'hAB34EF) begin errors++; $display("FAIL mask_dout1: got %h want ab34ef", dout1); end
        step(1'b0, 1'b1, 1'b1, 4'd7, 24'h999999, 24'hFFFFFF);
        checks += 2;
        if (dout2 !== 24'hAB34EF) begin errors++; $display("FAIL mask_dout2: got %h want ab34ef", dout2); end
        if (dout1 !== 24'hAB34EF) begin errors++; $display("FAIL men0_hold1: got %h want ab34ef", dout1); end
        step(1'b1, 1'b1, 1'b0, 4'd4, 24'h777777, 24'hFFFFFF);
        checks += 2;
        if (dout1 !== 24'hAB34EF) begin errors++; $display("FAIL wonly_hold1: got %h want ab34ef", dout1); end
        if (dout2 !== 24'hAB34EF) begin errors++; $display("FAIL wonly_hold2: got %h want ab34ef", dout2); end
    endtask

    task automatic test_write_through();
        step(1'b1, 1'b1, 1'b1, 4'd5, 24'h5A5A5A, 24'hFFFFFF);
        checks += 2;
        if (dout1 !== 24'h5A5A5A) begin errors++; $display("FAIL wt_dout1: got %h want 5a5a5a", dout1); end
        if (dout2 !== 24'hAB34EF) begin errors++; $display("FAIL wt_early2: got %h want ab34ef", dout2); end
        step(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0);
        checks++;
        if (dout2 !== 24'h5A5A5A) begin errors++; $display("FAIL wt_dout2: got %h want 5a5a5a", dout2); end
        step(1'b1, 1'b1, 1'b1, 4'd5, 24'h111111, 24'h000000);
        checks++;
        if (dout1 !== 24'h5A5A5A) begin errors++; $display("FAIL bm0_dout1: got %h want 5a5a5a", dout1); end
        step(1'b1, 1'b0, 1'b1, 4'd5, 24'h0, 24'h0);
        checks += 2;
        if (dout1 !== 24'h5A5A5A) begin errors++; $display("FAIL bm0_mem1: got %h want 5a5a5a", dout1); end
        if (dout2 !== 24'h5A5A5A) begin errors++; $display("FAIL bm0_dout2: got %h want 5a5a5a", dout2); end
    endtask

    task automatic test_err();
        step(1'b1, 1'b1, 1'b0, 4'd12, 24'hFFFFFF, 24'hFFFFFF);
        checks += 3;
        if (err2 !== 1'b1) begin errors++; $display("FAIL err_pulse2: got %b want 1", err2); end
        if (err1 !== 1'b0) begin errors++; $display("FAIL err_valid1: got %b want 0", err1); end
        if (dout2 !== 24'h5A5A5A) begin errors++; $display("FAIL err_hold2: got %h want 5a5a5a", dout2); end
        step(1'b1, 1'b0, 1'b1, 4'd2, 24'h0, 24'h0);
        checks += 2;
        if (err2 !== 1'b0) begin errors++; $display("FAIL err_clear2: got %b want 0", err2); end
        if (dout1 !== 24'h0) begin errors++; $display("FAIL err_rd2_1: got %h want 0", dout1); end
        step(1'b1, 1'b0, 1'b1, 4'd12, 24'h0, 24'h0);
        checks += 3;
        if (dout1 !== 24'hFFFFFF) begin errors++; $display("FAIL err_rd12_1: got %h want ffffff", dout1); end
        if (dout2 !== 24'h0) begin errors++; $display("FAIL err_alias2: got %h want 0", dout2); end
        if (err2 !== 1'b1) begin errors++; $display("FAIL err_rd_pulse2: got %b want 1", err2); end
        step(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0);
        checks += 2;
        if (dout2 !== 24'h0) begin errors++; $display("FAIL err_noupd2: got %h want 0", dout2); end
        if (err2 !== 1'b0) begin errors++; $display("FAIL err_one_cycle2: got %b want 0", err2); end
    endtask

    task automatic test_random();
        logic [23:0] b;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 3));
            b = r == 0 ? 24'h0 : r == 1 ? 24'hFFFFFF : 24'($urandom);
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom), 24'($urandom), b);
            checks += 4;
            if (dout1 !== e_dout1) begin errors++; $display("FAIL rand_dout1[%0d]: got %h want %h", i, dout1, e_dout1); end
            if (dout2 !== e_dout2) begin errors++; $display("FAIL rand_dout2[%0d]: got %h want %h", i, dout2, e_dout2); end
            if (err1 !== e_err1) begin errors++; $display("FAIL rand_err1[%0d]: got %b want %b", i, err1, e_err1); end
            if (err2 !== e_err2) begin errors++; $display("FAIL rand_err2[%0d]: got %b want %b", i, err2, e_err2); end
        end
    endtask

    task automatic test_inflight_reset();
        step(1'b1, 1'b1, 1'b0, 4'd1, 24'h111AAA, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b0, 4'd2, 24'h222BBB, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b0, 4'd3, 24'h333CCC, 24'hFFFFFF);
        step(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 1'b1, 4'd1, 24'h0, 24'h0);
        checks++;
        if (dout1 !== 24'h111AAA) begin errors++; $display("FAIL b2b_1_1: got %h want 111aaa", dout1); end
        step(1'b1, 1'b0, 1'b1, 4'd2, 24'h0, 24'h0);
        checks += 2;
        if (dout1 !== 24'h222BBB) begin errors++; $display("FAIL b2b_1_2: got %h want 222bbb", dout1); end
        if (dout2 !== 24'h111AAA) begin errors++; $display("FAIL b2b_2_1: got %h want 111aaa", dout2); end
        step(1'b1, 1'b0, 1'b1, 4'd3, 24'h0, 24'h0);
        checks += 2;
        if (dout1 !== 24'h333CCC) begin errors++; $display("FAIL b2b_1_3: got %h want 333ccc", dout1); end
        if (dout2 !== 24'h222BBB) begin errors++; $display("FAIL b2b_2_2: got %h want 222bbb", dout2); end
        men = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (dout1 !== 24'h0) begin errors++; $display("FAIL flight_rst1: got %h want 0", dout1); end
        if (dout2 !== 24'h0) begin errors++; $display("FAIL flight_rst2: got %h want 0", dout2); end
        #10;
        rst_n = 1'b1;
        model_reset();
        wait_fill();
        checks += 3;
        if (dout2 !== 24'h0) begin errors++; $display("FAIL flight_drop2: got %h want 0", dout2); end
        if (n1 != 16) begin errors++; $display("FAIL flight_fill1: got %0d want 16", n1); end
        if (n2 != 10) begin errors++; $display("FAIL flight_fill2: got %0d want 10", n2); end
    endtask

    task automatic test_mid_fill_reset();
        step(1'b1, 1'b1, 1'b0, 4'd8, 24'hC0FFEE, 24'hFFFFFF);
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        model_reset();
        men = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL midfill_busy: got %b want 1", busy1); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL midfill_abort1: got %b want 0", busy1); end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL midfill_abort2: got %b want 0", busy2); end
        #10;
        rst_n = 1'b1;
        wait_fill();
        checks += 2;
        if (n1 != 16) begin errors++; $display("FAIL refill_len1: got %0d want 16", n1); end
        if (n2 != 10) begin errors++; $display("FAIL refill_len2: got %0d want 10", n2); end
        step(1'b1, 1'b0, 1'b1, 4'd8, 24'h0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0);
        checks += 2;
        if (dout1 !== 24'h0) begin errors++; $display("FAIL refill_zero1: got %h want 0", dout1); end
        if (dout2 !== 24'h0) begin errors++; $display("FAIL refill_zero2: got %h want 0", dout2); end
    endtask

    initial begin
        test_reset();
        test_fill_zero();
        test_mask();
        test_write_through();
        test_err();
        test_random();
        test_inflight_reset();
        test_mid_fill_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
